// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// Bundle between the functional-unit writeback ports, the writeback arbiter and
// the scoreboard result-write port.
//   slave  : the arbiter. It receives the per-port requests and the scoreboard's
//            wb_ready_i, and drives ready_o plus the registered wb_* outputs.
//   master : the other side (functional units and scoreboard). It drives the
//            requests, flush_i and wb_ready_i.
// Signals:
//   flush_i        pipeline flush
//   valid_i        per-port result valid                 [NR_WB_PORTS]
//   ready_o        per-port grant, one-hot or zero       [NR_WB_PORTS]
//   trans_id_i     per-port tag, port i at [i*TRANS_ID_BITS +: TRANS_ID_BITS]
//   result_i       per-port result, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ex_valid_i     per-port exception flag               [NR_WB_PORTS]
//   wb_valid_o     output register holds a result
//   wb_ready_i     scoreboard accepts the output this cycle
//   wb_trans_id_o  tag of the held result
//   wb_result_o    held result
//   wb_ex_valid_o  held result carries an exception
// -----------------------------------------------------------------------------
interface wb_arbiter_if #(
  parameter int unsigned NR_WB_PORTS   = 4,
  parameter int unsigned TRANS_ID_BITS = 2,
  parameter int unsigned DATA_WIDTH    = 64
);
  logic                                   flush_i;
  logic [NR_WB_PORTS-1:0]                 valid_i;
  logic [NR_WB_PORTS-1:0]                 ready_o;
  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]   trans_id_i;
  logic [NR_WB_PORTS*DATA_WIDTH-1:0]      result_i;
  logic [NR_WB_PORTS-1:0]                 ex_valid_i;
  logic                                   wb_valid_o;
  logic                                   wb_ready_i;
  logic [TRANS_ID_BITS-1:0]               wb_trans_id_o;
  logic [DATA_WIDTH-1:0]                  wb_result_o;
  logic                                   wb_ex_valid_o;

  modport slave (
    input  flush_i, valid_i, trans_id_i, result_i, ex_valid_i, wb_ready_i,
    output ready_o, wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o
  );

  modport master (
    output flush_i, valid_i, trans_id_i, result_i, ex_valid_i, wb_ready_i,
    input  ready_o, wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Round-robin writeback arbiter. Each cycle at most one valid functional-unit
// port is granted (ready_o one-hot) into a single registered output stage that
// the scoreboard drains with wb_valid_o/wb_ready_i. A new result may load in the
// same cycle the held one drains, giving one result per cycle. A flush discards
// the held result and blocks grants for that cycle without moving the pointer.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    wb_arbiter_if.slave (requests, grants, output stage)
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int unsigned NR_WB_PORTS   = 4,
  parameter int unsigned TRANS_ID_BITS = 2,
  parameter int unsigned DATA_WIDTH    = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wb_arbiter_if.slave    bus
);

  localparam int unsigned PTR_W = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

  // Per-port views of the flattened request buses.
  logic [TRANS_ID_BITS-1:0] port_tid [NR_WB_PORTS];
  logic [DATA_WIDTH-1:0]    port_res [NR_WB_PORTS];

  for (genvar g = 0; g < NR_WB_PORTS; g++) begin : g_unpack
    assign port_tid[g] = bus.trans_id_i[g*TRANS_ID_BITS +: TRANS_ID_BITS];
    assign port_res[g] = bus.result_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [PTR_W-1:0]         rr_ptr_q,      rr_ptr_d;
  logic                     wb_valid_q,    wb_valid_d;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_q, wb_trans_id_d;
  logic [DATA_WIDTH-1:0]    wb_result_q,   wb_result_d;
  logic                     wb_ex_valid_q, wb_ex_valid_d;

  logic                     slot_free;
  logic                     grant_en;
  logic                     grant_vld;
  logic [PTR_W-1:0]         grant_idx;
  logic [NR_WB_PORTS-1:0]   ready;

  // The slot is free when empty or when the held result drains this cycle.
  assign slot_free = !wb_valid_q || bus.wb_ready_i;
  // Grants are also held off during reset so no requester sees a transfer
  // that the output register would then drop.
  assign grant_en  = slot_free && !bus.flush_i && !rst_i;

  // Round-robin search: first valid port at or above rr_ptr, wrapping.
  always_comb begin : grant_search
    logic [PTR_W-1:0] cand;
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch; '=' is used here
    // because later loop iterations must see the values set by earlier ones.
    cand      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    ready     = '0;
    for (int unsigned i = 0; i < NR_WB_PORTS; i++) begin
      cand = PTR_W'((32'(rr_ptr_q) + i) % NR_WB_PORTS);
      if (grant_en && !grant_vld && bus.valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_vld) ready[grant_idx] = 1'b1;
  end

  // Next state of the pointer and output register.
  always_comb begin : next_state
    rr_ptr_d      = rr_ptr_q;
    wb_valid_d    = wb_valid_q;
    wb_trans_id_d = wb_trans_id_q;
    wb_result_d   = wb_result_q;
    wb_ex_valid_d = wb_ex_valid_q;
    if (bus.flush_i) begin
      // A handshake coinciding with a flush is void; the pointer stays put.
      wb_valid_d = 1'b0;
    end else if (grant_vld) begin
      wb_valid_d    = 1'b1;
      wb_trans_id_d = port_tid[grant_idx];
      wb_result_d   = port_res[grant_idx];
      wb_ex_valid_d = bus.ex_valid_i[grant_idx];
      rr_ptr_d      = PTR_W'((32'(grant_idx) + 1) % NR_WB_PORTS);
    end else if (bus.wb_ready_i) begin
      // Drained with nothing to replace it; data fields keep their values.
      wb_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use '<=' so every flop samples the pre-edge values
  // regardless of the order in which always blocks are evaluated.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q      <= '0;
      wb_valid_q    <= 1'b0;
      wb_trans_id_q <= '0;
      wb_result_q   <= '0;
      wb_ex_valid_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      wb_valid_q    <= wb_valid_d;
      wb_trans_id_q <= wb_trans_id_d;
      wb_result_q   <= wb_result_d;
      wb_ex_valid_q <= wb_ex_valid_d;
    end
  end

  assign bus.ready_o       = ready;
  assign bus.wb_valid_o    = wb_valid_q;
  assign bus.wb_trans_id_o = wb_trans_id_q;
  assign bus.wb_result_o   = wb_result_q;
  assign bus.wb_ex_valid_o = wb_ex_valid_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Self-checking bench for wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic (requests obeying the hold rule,
// back-pressure, flushes, occasional resets). A behavioural model tracks the
// pointer as an integer and the output stage as plain variables and is
// compared against the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
  localparam int N    = 4;
  localparam int TIDW = 2;
  localparam int DW   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            flush;
  logic            wb_rdy;
  logic [N-1:0]    vld;
  logic [TIDW-1:0] tid [N];
  logic [DW-1:0]   res [N];
  logic            ex  [N];

  int n_tests = 0;
  int n_fail  = 0;

  wb_arbiter_if #(.NR_WB_PORTS(N), .TRANS_ID_BITS(TIDW), .DATA_WIDTH(DW)) bus ();

  wb_arbiter #(.NR_WB_PORTS(N), .TRANS_ID_BITS(TIDW), .DATA_WIDTH(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  assign bus.valid_i    = vld;
  assign bus.flush_i    = flush;
  assign bus.wb_ready_i = wb_rdy;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.trans_id_i[g*TIDW +: TIDW] = tid[g];
    assign bus.result_i[g*DW +: DW]       = res[g];
    assign bus.ex_valid_i[g]              = ex[g];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model, evaluated on the falling edge (inputs are stable then).
  // ---------------------------------------------------------------------------
  int            m_ptr   = 0;
  bit            m_valid = 1'b0;
  int            m_tid   = 0;
  logic [DW-1:0] m_res   = '0;
  bit            m_ex    = 1'b0;

  always @(negedge clk) begin : model
    logic [N-1:0] exp_rdy;
    int win;
    int p;
    check("wb_valid",    64'(bus.wb_valid_o),    64'(m_valid));
    check("wb_trans_id", 64'(bus.wb_trans_id_o), 64'(m_tid));
    check("wb_result",   bus.wb_result_o,        m_res);
    check("wb_ex_valid", 64'(bus.wb_ex_valid_o), 64'(m_ex));

    exp_rdy = '0;
    win     = -1;
    if (!rst && !flush && (!m_valid || wb_rdy)) begin
      for (int j = 0; j < N; j++) begin
        p = (m_ptr + j) % N;
        if (win < 0 && vld[p]) win = p;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("ready", 64'(bus.ready_o), 64'(exp_rdy));

    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++)
        if (vld[a] && vld[b] && tid[a] == tid[b]) begin
          n_fail++;
          $display("FAIL dup_tag: ports %0d and %0d both carry tag %0d", a, b, tid[a]);
        end

    if (rst) begin
      m_ptr = 0; m_valid = 1'b0; m_tid = 0; m_res = '0; m_ex = 1'b0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (win >= 0) begin
      m_valid = 1'b1;
      m_tid   = int'(tid[win]);
      m_res   = res[win];
      m_ex    = ex[win];
      m_ptr   = (win + 1) % N;
    end else if (wb_rdy) begin
      m_valid = 1'b0;
    end
  end

  // New request on port i with a tag not held by any other valid port.
  task automatic new_req(input int i);
    int  t0;
    int  t;
    bit  used;
    bit  found;
    t0    = $urandom_range(0, N - 1);
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      t    = (t0 + k) % N;
      used = 1'b0;
      for (int j = 0; j < N; j++)
        if (j != i && vld[j] && int'(tid[j]) == t) used = 1'b1;
      if (!used && !found) begin
        tid[i] = TIDW'(t);
        found  = 1'b1;
      end
    end
    res[i] = {$urandom, $urandom};
    ex[i]  = 1'($urandom_range(0, 1));
    vld[i] = found;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] last_rdy;
  bit           last_kill;

  initial begin
    // Reset with all ports requesting.
    rst = 1'b1; flush = 1'b0; wb_rdy = 1'b1; vld = 4'b1111;
    for (int i = 0; i < N; i++) begin
      tid[i] = TIDW'(i);
      res[i] = 64'hA0 + 64'(i);
      ex[i]  = 1'b0;
    end
    repeat (2) begin
      @(negedge clk);
      check("rst_ready",    64'(bus.ready_o),    64'h0);
      check("rst_wb_valid", 64'(bus.wb_valid_o), 64'h0);
    end
    step(); rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.ready_o), 64'b0001);
    check("post_rst_valid", 64'(bus.wb_valid_o), 64'h0);

    // Round robin: A0, A1, A2, A3, A0 on consecutive cycles.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_result", bus.wb_result_o, 64'hA0 + 64'(k % 4));
      check("rr_tid",    64'(bus.wb_trans_id_o), 64'(k % 4));
    end

    // Pointer wrap: grant port 2, then ports 0 and 1 valid.
    step(); vld = 4'b0100;
    @(negedge clk); check("wrap_p2", 64'(bus.ready_o), 64'b0100);
    step(); vld = 4'b0011;
    @(negedge clk); check("wrap_first", 64'(bus.ready_o), 64'b0001);
    step(); vld = 4'b0010;
    @(negedge clk);
    check("wrap_second", 64'(bus.ready_o), 64'b0010);
    check("wrap_res0",   bus.wb_result_o, 64'hA0);

    // Back-pressure: port 1 holds 0x55/tag 2, port 3 waits.
    step(); tid[1] = 2'd2; res[1] = 64'h55; vld = 4'b0010;
    @(negedge clk);
    check("bp_res1", bus.wb_result_o, 64'hA1);
    check("bp_load", 64'(bus.ready_o), 64'b0010);
    step(); wb_rdy = 1'b0; vld = 4'b1000; tid[3] = 2'd3; res[3] = 64'h77;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_res",   bus.wb_result_o, 64'h55);
      check("bp_hold_tid",   64'(bus.wb_trans_id_o), 64'd2);
      check("bp_hold_ready", 64'(bus.ready_o), 64'h0);
      step();
    end
    wb_rdy = 1'b1;
    @(negedge clk); check("bp_release", 64'(bus.ready_o), 64'b1000);

    // Flush with a held result and ports 0/1 valid.
    step(); vld = 4'b0011; tid[0] = 2'd0; res[0] = 64'h11; tid[1] = 2'd1; res[1] = 64'h12;
    flush = 1'b1;
    @(negedge clk);
    check("flush_ready", 64'(bus.ready_o), 64'h0);
    check("flush_held",  bus.wb_result_o, 64'h77);
    step(); flush = 1'b0;
    @(negedge clk);
    check("flush_drop", 64'(bus.wb_valid_o), 64'h0);
    check("flush_ptr",  64'(bus.ready_o), 64'b0001);
    step(); vld = 4'b0010;
    @(negedge clk); check("flush_res0", bus.wb_result_o, 64'h11);

    // Exception passthrough on port 2.
    step(); vld = 4'b0100; tid[2] = 2'd1; res[2] = 64'hDEAD; ex[2] = 1'b1;
    @(negedge clk);
    check("ex_grant", 64'(bus.ready_o), 64'b0100);
    check("ex_prev",  bus.wb_result_o, 64'h12);
    step(); vld = 4'b0000;
    @(negedge clk);
    check("ex_flag",   64'(bus.wb_ex_valid_o), 64'h1);
    check("ex_tid",    64'(bus.wb_trans_id_o), 64'h1);
    check("ex_result", bus.wb_result_o, 64'hDEAD);

    // Randomized traffic.
    repeat (3000) begin
      @(negedge clk);
      last_rdy  = bus.ready_o;
      last_kill = rst || flush;
      step();
      rst    = ($urandom_range(0, 999) < 3);
      flush  = ($urandom_range(0, 99) < 5);
      wb_rdy = ($urandom_range(0, 99) < 70);
      for (int i = 0; i < N; i++) begin
        if (!vld[i] || last_rdy[i] || last_kill) begin
          vld[i] = 1'b0;
          if ($urandom_range(0, 1) == 1) new_req(i);
        end
      end
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the functional units (ALU, branch, LSU, multiplier, CSR) and the scoreboard's single result-write port. Up to `NR_WB_PORTS` units present finished results tagged with a scoreboard `trans_id`. A round-robin arbiter grants one of them per cycle into a registered output stage, which the scoreboard drains with a valid/ready handshake. On a flush, everything in flight is discarded.

## Interface
- `NR_WB_PORTS`, 4: number of requesting writeback ports.
- `TRANS_ID_BITS`, 2: width of the scoreboard transaction id (log2 of 4 scoreboard entries).
- `DATA_WIDTH`, 64: result width.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `flush_i`  in  1  pipeline flush; drops the output register and blocks grants this cycle.
- `valid_i`  in  NR_WB_PORTS  per-port result valid.
- `ready_o`  out  NR_WB_PORTS  per-port grant/accept, one-hot or zero.
- `trans_id_i`  in  NR_WB_PORTS*TRANS_ID_BITS  per-port scoreboard tag; port i occupies bits [i*TRANS_ID_BITS +: TRANS_ID_BITS].
- `result_i`  in  NR_WB_PORTS*DATA_WIDTH  per-port result; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ex_valid_i`  in  NR_WB_PORTS  per-port flag: the result carries an exception.
- `wb_valid_o`  out  1  output register holds a result.
- `wb_ready_i`  in  1  scoreboard accepts the output this cycle.
- `wb_trans_id_o`  out  TRANS_ID_BITS  tag of the held result.
- `wb_result_o`  out  DATA_WIDTH  held result.
- `wb_ex_valid_o`  out  1  held result carries an exception.

## Operation
- **State**
  - Round-robin pointer `rr_ptr` ($clog2(NR_WB_PORTS) bits).
  - Output register: valid bit, trans_id, result and ex flag.
- **Output slot free:** `slot_free = !wb_valid_o || wb_ready_i`.
- **Grant (combinational)**
  - A grant is possible only when `slot_free` is high and `flush_i` is low.
  - The winner is the first port with `valid_i` high, searching upward from `rr_ptr` and wrapping modulo `NR_WB_PORTS`.
  - `ready_o` is one-hot on the winner and zero otherwise.
  - `ready_o` never asserts for a port whose `valid_i` is low.
- **Handshake rules (requester side)**
  - A requester holds `valid_i`, `trans_id_i`, `result_i` and `ex_valid_i` stable until the cycle `ready_o` is high.
  - The transfer completes in that cycle.
  - A requester may deassert `valid_i` without a transfer only on a flush.
- **On grant to port k (clock edge)**
  - The output register loads port k's trans_id, result and ex flag, and `wb_valid_o` becomes 1.
  - `rr_ptr` becomes (k+1) mod `NR_WB_PORTS`.
- **No grant, `wb_ready_i` high:** `wb_valid_o` becomes 0. The data fields hold their values (don't-care).
- **No grant, `wb_ready_i` low:** the output register holds all fields unchanged.
- **Flush**
  - `wb_valid_o` becomes 0 on the next edge, regardless of `wb_ready_i`.
  - `ready_o` is forced to 0 during the flush cycle.
  - `rr_ptr` is unchanged.
- **Simultaneous flush and `wb_ready_i` with `wb_valid_o` high:** the scoreboard sees the handshake, but it must ignore it because it is being flushed too. The arbiter treats the cycle as a flush.
- **Reset**
  - `rr_ptr` = 0.
  - `wb_valid_o` = 0, `wb_trans_id_o` = 0, `wb_result_o` = 0, `wb_ex_valid_o` = 0.
  - `ready_o` = 0 while `rst_i` is high.
  - Reset in mid-transfer drops the held result.
- **Illegal input:** two valid ports carrying the same trans_id is illegal. The arbiter does not check for it; the bench asserts against it.

## Timing
- Latency: a result granted in cycle N is visible on `wb_*_o` in cycle N+1.
- Throughput: one result per cycle when `wb_ready_i` stays high.
- `ready_o` depends combinationally on `valid_i`, `rr_ptr`, `wb_valid_o`, `wb_ready_i` and `flush_i`.
  - There is no combinational path from any `valid_i` to `wb_*_o`.
- Fairness: a continuously valid port is granted within `NR_WB_PORTS` grant opportunities.
- Back-pressure: while `wb_valid_o=1` and `wb_ready_i=0`, all `ready_o` are 0. With `wb_ready_i=1`, a new grant loads in the same cycle the old result drains (no bubble).

## Test plan
- **Reset:** assert `rst_i` for 2 cycles with all `valid_i`=4'b1111 → `ready_o`=0 and `wb_valid_o`=0. In the first cycle after release, `ready_o`=4'b0001.
- **Round robin:** all four ports continuously valid, tags 0..3, results 0xA0..0xA3, `wb_ready_i`=1 → output sequence 0xA0, 0xA1, 0xA2, 0xA3, 0xA0, one per cycle, each 1 cycle after its grant.
- **Pointer wrap:** `rr_ptr`=3 after a port-2 grant. Ports 0 and 1 valid → port 0 granted first, then port 1.
- **Back-pressure:** port 1 result 0x55, tag 2, `wb_ready_i`=0 for 3 cycles with port 3 also valid → output holds 0x55/tag 2 and `ready_o`=0. When `wb_ready_i` rises, port 3 is granted in that same cycle.
- **Flush:** `wb_valid_o`=1 and port 0 valid, `flush_i` for 1 cycle → `ready_o`=0 in that cycle and `wb_valid_o`=0 the next cycle. The grant order after the flush continues from the unchanged `rr_ptr`.
- **Exception passthrough:** port 2 `ex_valid_i`=1, tag 1, result 0xDEAD → `wb_ex_valid_o`=1, `wb_trans_id_o`=1, `wb_result_o`=0xDEAD one cycle later.
